// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - handshake/stream bundle for the serial pattern transmitter
//
// Signals:
//   start        request to begin a transfer (sampled only when idle)
//   pattern      PAT_W-bit pattern, latched on an accepted start
//   rep_cnt      extra repetitions, latched on an accepted start
//   hold         stall; freezes transmission while high
//   bit_out      serial data, MSB-first
//   bit_valid    bit_out carries a new bit this cycle
//   frame_start  high with the first bit of each frame
//   busy         high from accepted start through the done cycle
//   done         one-cycle pulse after the final bit
// Modports: master drives requests and observes the stream; slave is the transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep_cnt;
  logic             hold;
  logic             bit_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, rep_cnt, hold,
    input  bit_out, bit_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, rep_cnt, hold,
    output bit_out, bit_valid, frame_start, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first, repeated frames
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   tx   seq_pattern_tx_if.slave: start/pattern/rep_cnt/hold in,
//        bit_out/bit_valid/frame_start/busy/done out (all registered)
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_tx_if.slave    tx
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;       // latched pattern, used to reload each frame
  logic [PAT_W-1:0] shreg_q, shreg_d;   // bits of the current frame not yet presented
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d; // index of the bit currently on bit_out
  logic [CNT_W-1:0] rep_q, rep_d;       // frames still to send after the current one
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      rep_q         <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      rep_q         <= rep_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    rep_d         = rep_q;
    bit_out_d     = bit_out_q;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d    = 1'b0;
        bit_out_d = 1'b0;
        if (tx.start) begin
          state_d       = S_SHIFT;
          pat_d         = tx.pattern;
          rep_d         = tx.rep_cnt;
          bit_out_d     = tx.pattern[PAT_W-1];
          shreg_d       = {tx.pattern[PAT_W-2:0], 1'b0};
          bit_cnt_d     = '0;
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end
      end

      S_SHIFT: begin
        // The bit on bit_out was already sent with bit_valid=1; a held edge
        // just idles with bit_valid low, and the next unheld edge moves on.
        if (!tx.hold) begin
          if (bit_cnt_q == LAST_IDX) begin
            if (rep_q != '0) begin
              rep_d         = rep_q - 1'b1;
              bit_out_d     = pat_q[PAT_W-1];
              shreg_d       = {pat_q[PAT_W-2:0], 1'b0};
              bit_cnt_d     = '0;
              bit_valid_d   = 1'b1;
              frame_start_d = 1'b1;
            end else begin
              state_d   = S_DONE;
              bit_out_d = 1'b0;
              shreg_d   = '0;
              bit_cnt_d = '0;
              done_d    = 1'b1;
            end
          end else begin
            bit_out_d   = shreg_q[PAT_W-1];
            shreg_d     = {shreg_q[PAT_W-2:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + 1'b1;
            bit_valid_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        bit_out_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        bit_out_d = 1'b0;
      end
    endcase
  end

  assign tx.bit_out     = bit_out_q;
  assign tx.bit_valid   = bit_valid_q;
  assign tx.frame_start = frame_start_q;
  assign tx.busy        = busy_q;
  assign tx.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a transfer is the queue of every bit it must emit.
  int   m_mode;          // 0 idle, 1 transmitting, 2 done cycle
  bit   m_q[$];
  int   m_sent;
  logic m_out, m_valid, m_fs, m_busy, m_done;

  // Per-run accumulators
  int          nvalid, nfs, nbusy, ndone;
  logic [63:0] coll;

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rep;
    int          hold_at;
    int          hold_len;
    int          exp_bits;
    int          exp_frames;
    int          exp_busy;
    logic [63:0] exp_stream;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_sent = 0;
    m_out = 0; m_valid = 0; m_fs = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_emit();
    m_out   = m_q.pop_front();
    m_valid = 1;
    m_fs    = (m_sent % PAT_W) == 0;
    m_sent++;
    m_busy  = 1;
    m_done  = 0;
  endtask

  task automatic model_step(input logic st, input logic [3:0] pat, input logic [3:0] rep, input logic hld);
    case (m_mode)
      0: begin
        m_valid = 0; m_fs = 0; m_done = 0; m_busy = 0; m_out = 0;
        if (st) begin
          m_q.delete();
          m_sent = 0;
          for (int f = 0; f <= int'(rep); f++)
            for (int b = PAT_W - 1; b >= 0; b--)
              m_q.push_back(pat[b]);
          m_mode = 1;
          model_emit();
        end
      end
      1: begin
        if (hld) begin
          m_valid = 0; m_fs = 0;
        end else if (m_q.size() == 0) begin
          m_mode = 2;
          m_out = 0; m_valid = 0; m_fs = 0; m_done = 1; m_busy = 1;
        end else begin
          model_emit();
        end
      end
      default: begin
        m_mode = 0;
        m_out = 0; m_valid = 0; m_fs = 0; m_done = 0; m_busy = 0;
      end
    endcase
  endtask

  task automatic clear_acc();
    nvalid = 0; nfs = 0; nbusy = 0; ndone = 0; coll = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(bus.start, bus.pattern, bus.rep_cnt, bus.hold);
    #1;
    chk("cycle", {59'd0, bus.bit_out, bus.bit_valid, bus.frame_start, bus.busy, bus.done},
                 {59'd0, m_out, m_valid, m_fs, m_busy, m_done});
    if (bus.bit_valid) begin
      nvalid++;
      coll = {coll[62:0], bus.bit_out};
    end
    if (bus.frame_start) nfs++;
    if (bus.busy) nbusy++;
    if (bus.done) ndone++;
  endtask

  task automatic run_to_idle(input string name);
    int guard;
    guard = 0;
    while (ndone == 0 && guard < 200) begin
      tick();
      guard++;
    end
    chk({name, "_done_seen"}, 64'(ndone), 64'd1);
    tick();
    chk({name, "_busy_low"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  guard;
    bit  held;
    clear_acc();
    bus.pattern = v.pat;
    bus.rep_cnt = v.rep;
    bus.start   = 1'b1;
    tick();
    chk($sformatf("v%0d_first_bit", idx),
        {60'd0, bus.bit_valid, bus.frame_start, bus.bit_out, bus.busy},
        {60'd0, 1'b1, 1'b1, v.pat[3], 1'b1});
    bus.start   = 1'b0;
    bus.pattern = 4'($urandom);
    bus.rep_cnt = 4'($urandom);
    held  = 0;
    guard = 0;
    while (ndone == 0 && guard < 200) begin
      if (!held && v.hold_at != 0 && nvalid == v.hold_at) begin
        bus.hold = 1'b1;
        repeat (v.hold_len) tick();
        bus.hold = 1'b0;
        held = 1;
      end else begin
        tick();
      end
      guard++;
    end
    tick();
    chk($sformatf("v%0d_bits", idx),   64'(nvalid), 64'(v.exp_bits));
    chk($sformatf("v%0d_frames", idx), 64'(nfs),    64'(v.exp_frames));
    chk($sformatf("v%0d_done", idx),   64'(ndone),  64'd1);
    chk($sformatf("v%0d_busy", idx),   64'(nbusy),  64'(v.exp_busy));
    chk($sformatf("v%0d_stream", idx), coll,        v.exp_stream);
    chk($sformatf("v%0d_idle", idx),   64'(bus.busy), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1011, 4'd0,  0, 0,  4, 1,  5, 64'hB};
    vecs[1] = '{4'b1011, 4'd2,  0, 0, 12, 3, 13, 64'hBBB};
    vecs[2] = '{4'b1100, 4'd0,  2, 3,  4, 1,  8, 64'hC};
    vecs[3] = '{4'b1001, 4'hF,  0, 0, 64, 16, 65, 64'h9999_9999_9999_9999};
    vecs[4] = '{4'b0110, 4'd1,  5, 2,  8, 2, 11, 64'h66};
    vecs[5] = '{4'b1111, 4'd0,  0, 0,  4, 1,  5, 64'hF};

    bus.start = 1'b0; bus.pattern = '0; bus.rep_cnt = '0; bus.hold = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_state", {59'd0, bus.bit_out, bus.bit_valid, bus.frame_start, bus.busy, bus.done}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // start held high through SHIFT and DONE: only the IDLE cycle re-accepts
    clear_acc();
    bus.pattern = 4'b1011; bus.rep_cnt = 4'd0; bus.start = 1'b1;
    tick();
    bus.pattern = 4'b0000;
    repeat (3) tick();
    chk("ign_stream", coll, 64'hB);
    tick();
    chk("ign_done", 64'(bus.done), 64'd1);
    tick();
    chk("ign_idle", 64'(bus.busy), 64'd0);
    tick();
    chk("reaccept", {61'd0, bus.busy, bus.bit_valid, bus.bit_out}, {61'd0, 1'b1, 1'b1, 1'b0});
    bus.start = 1'b0;
    clear_acc();
    run_to_idle("reaccept");

    // asynchronous reset in the 3rd bit of a two-frame transfer
    clear_acc();
    bus.pattern = 4'b1011; bus.rep_cnt = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre_rst_bits", 64'(nvalid), 64'd3);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {59'd0, bus.bit_out, bus.bit_valid, bus.frame_start, bus.busy, bus.done}, 64'd0);
    model_reset();
    tick();
    chk("rst_no_done", 64'(ndone), 64'd0);
    rst = 1'b0;
    clear_acc();
    bus.pattern = 4'b1010; bus.rep_cnt = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_to_idle("post_rst");
    chk("post_rst_stream", coll, 64'hA);

    // randomized traffic against the queue model
    for (int n = 0; n < 2000; n++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.pattern = 4'($urandom);
      bus.rep_cnt = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      bus.hold    = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
